depth_result_stream_tx: RTL and testbench

- Avalon-ST source that drives the 8-bit depth-result stream (avl_stream_rgb_data_result) back into the Qsys/PCIe subsystem on clk_user_out.
- Accepts raster-ordered depth pixels from the network output stage, buffers them in a small show-ahead FIFO and frames each image as one packet with startofpacket/endofpacket.
- Honours sink backpressure and reports frame count and framing errors.

---
 rtl/depth_result_stream_tx_if.sv | 14 +
 rtl/depth_result_stream_tx.sv | 129 ++++++++++++
 tb/tb_depth_result_stream_tx.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/depth_result_stream_tx_if.sv
// Avalon-ST source bundle for the depth-result stream: valid/ready handshake
// plus data and packet framing flags.
interface depth_result_stream_tx_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              sop;
  logic              eop;

  modport master (output valid, output data, output sop, output eop, input ready);
  modport slave  (input valid, input data, input sop, input eop, output ready);
endinterface

// File: rtl/depth_result_stream_tx.sv
// Frames raster-ordered depth pixels into one Avalon-ST packet per image,
// buffered through a small show-ahead FIFO with sink backpressure.
module depth_result_stream_tx #(
  parameter int DATA_W     = 8,
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 48,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  depth_result_stream_tx_if.master   st,
  output logic [CNT_W-1:0]           frame_cnt,
  output logic                       err_sof,
  input  logic                       clr_err,
  output logic                       busy
);

  localparam int PKT = IMG_W * IMG_H;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = (PKT > 1) ? $clog2(PKT) : 1;
  localparam int EW  = DATA_W + 2;

  typedef enum logic {IDLE, FRAME} wr_state_t;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]       count_reg, count_next;
  wr_state_t         state_reg, state_next;
  logic [PW-1:0]     pix_cnt_reg, pix_cnt_next;
  logic              rst_done_reg;
  logic [DATA_W-1:0] head_data_reg;
  logic              head_sop_reg, head_eop_reg;
  logic              push, pop, wr_sop, wr_eop, err_set;
  logic [EW-1:0]     wr_entry, head_next;

  assign in_ready = rst_done_reg && enable && (count_reg != (AW+1)'(FIFO_DEPTH));
  assign st.valid = (count_reg != '0);
  assign st.data  = head_data_reg;
  assign st.sop   = head_sop_reg;
  assign st.eop   = head_eop_reg;
  assign busy     = st.valid || (state_reg == FRAME);

  assign push     = in_valid && in_ready;
  assign pop      = st.valid && st.ready;
  assign wr_entry = {wr_eop, wr_sop, in_data};

  // Packet flags are decided at write time so the read side only replays them.
  always_comb begin
    wr_sop       = 1'b0;
    wr_eop       = 1'b0;
    err_set      = 1'b0;
    state_next   = state_reg;
    pix_cnt_next = pix_cnt_reg;
    if (push) begin
      if (in_sof) begin
        wr_sop  = 1'b1;
        err_set = (state_reg == FRAME);
        if (PKT == 1) begin
          wr_eop       = 1'b1;
          state_next   = IDLE;
          pix_cnt_next = '0;
        end else begin
          state_next   = FRAME;
          pix_cnt_next = PW'(1);
        end
      end else if (state_reg == IDLE) begin
        err_set = 1'b1;
      end else if (pix_cnt_reg == PW'(PKT - 1)) begin
        wr_eop       = 1'b1;
        state_next   = IDLE;
        pix_cnt_next = '0;
      end else begin
        pix_cnt_next = pix_cnt_reg + 1'b1;
      end
    end
  end

  assign count_next  = count_reg + (AW+1)'(push) - (AW+1)'(pop);
  assign rd_ptr_next = rd_ptr_reg + AW'(pop);
  // Bypass when this cycle's write lands exactly at the next head slot.
  assign head_next   = (push && (count_reg == (AW+1)'(pop))) ? wr_entry : mem[rd_ptr_next];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      state_reg     <= IDLE;
      pix_cnt_reg   <= '0;
      rst_done_reg  <= 1'b0;
      head_data_reg <= '0;
      head_sop_reg  <= 1'b0;
      head_eop_reg  <= 1'b0;
      frame_cnt     <= '0;
      err_sof       <= 1'b0;
    end else begin
      rst_done_reg <= 1'b1;
      wr_ptr_reg   <= wr_ptr_reg + AW'(push);
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      state_reg    <= state_next;
      pix_cnt_reg  <= pix_cnt_next;
      if (count_next != '0) begin
        {head_eop_reg, head_sop_reg, head_data_reg} <= head_next;
      end
      if (pop && head_eop_reg) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (err_set) begin
        err_sof <= 1'b1;
      end else if (clr_err) begin
        err_sof <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_depth_result_stream_tx.sv
// Randomized bench for depth_result_stream_tx with a queue-based packet model.
module tb_depth_result_stream_tx;

  localparam int PKT   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [1:0] frame_cnt;
  logic       err_sof;
  logic       busy;

  depth_result_stream_tx_if #(.DATA_W(8)) st_if ();

  depth_result_stream_tx #(
    .DATA_W(8), .IMG_W(4), .IMG_H(2), .FIFO_DEPTH(DEPTH), .CNT_W(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
    .in_sof(in_sof), .in_data(in_data), .in_ready(in_ready), .st(st_if),
    .frame_cnt(frame_cnt), .err_sof(err_sof), .clr_err(clr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       eop;
    logic       sop;
    logic [7:0] data;
  } ent_t;

  ent_t m_q[$];
  bit   m_in_frame;
  int   m_pos;
  bit   m_err;
  int   m_fc;
  bit   m_rst_done;
  int   chk_cnt;
  int   pass_cnt;
  int   pops;

  task automatic model_clear();
    m_q.delete();
    m_in_frame = 0;
    m_pos      = 0;
    m_err      = 0;
    m_fc       = 0;
    m_rst_done = 0;
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic step(input logic v, input logic sof, input logic [7:0] d,
                      input logic rdy, input logic en, input logic clr,
                      output logic accepted);
    logic exp_rdy, push, pop, set;
    ent_t e;
    in_valid = v; in_sof = sof; in_data = d; st_if.ready = rdy; enable = en; clr_err = clr;
    #1;
    exp_rdy = m_rst_done && en && (m_q.size() < DEPTH);
    chk_cnt++;
    if (in_ready !== exp_rdy) $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
    else pass_cnt++;
    chk_cnt++;
    if (st_if.valid !== (m_q.size() != 0))
      $display("FAIL st_valid: got %b expected %b", st_if.valid, m_q.size() != 0);
    else pass_cnt++;
    if (m_q.size() != 0) begin
      chk_cnt++;
      if ({st_if.eop, st_if.sop, st_if.data} !== m_q[0])
        $display("FAIL head: got eop=%b sop=%b data=%02h expected eop=%b sop=%b data=%02h",
                 st_if.eop, st_if.sop, st_if.data, m_q[0].eop, m_q[0].sop, m_q[0].data);
      else pass_cnt++;
    end
    push = v && exp_rdy;
    pop  = (m_q.size() != 0) && rdy;
    set  = 0;
    @(posedge clk);
    if (pop) begin
      e = m_q.pop_front();
      pops++;
      if (e.eop) m_fc = (m_fc + 1) % 4;
      $display("out data=%02h sop=%b eop=%b frame_cnt=%0d", e.data, e.sop, e.eop, m_fc);
    end
    if (push) begin
      e.data = d; e.sop = 0; e.eop = 0;
      if (sof) begin
        if (m_in_frame) set = 1;
        e.sop = 1; m_pos = 1; e.eop = (PKT == 1); m_in_frame = !e.eop;
      end else if (!m_in_frame) begin
        set = 1;
      end else begin
        m_pos++;
        if (m_pos == PKT) begin e.eop = 1; m_in_frame = 0; m_pos = 0; end
      end
      m_q.push_back(e);
    end
    if (set) m_err = 1;
    else if (clr) m_err = 0;
    m_rst_done = 1;
    accepted = push;
    @(negedge clk);
    chk_cnt++;
    if (frame_cnt !== 2'(m_fc)) $display("FAIL frame_cnt: got %0d expected %0d", frame_cnt, m_fc);
    else pass_cnt++;
    chk_cnt++;
    if (err_sof !== m_err) $display("FAIL err_sof: got %b expected %b", err_sof, m_err);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== ((m_q.size() != 0) || m_in_frame))
      $display("FAIL busy: got %b expected %b", busy, (m_q.size() != 0) || m_in_frame);
    else pass_cnt++;
  endtask

  // rdy_mode: 0 stalled, 1 ready, 2 random
  task automatic send_pixel(input logic [7:0] d, input logic sof, input int rdy_mode,
                            input logic clr);
    logic acc, r;
    int tries;
    acc = 0; tries = 0;
    while (!acc && tries < 50) begin
      r = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
      step(1, sof, d, r, 1, clr, acc);
      tries++;
    end
    chk_cnt++;
    if (!acc) $display("FAIL send_timeout: got no accept for %02h expected accept within 50 cycles", d);
    else pass_cnt++;
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    while (m_q.size() != 0 && n < 40) begin
      step(0, 0, 8'h00, 1, 1, 0, acc);
      n++;
    end
    chk_cnt++;
    if (m_q.size() != 0) $display("FAIL drain_timeout: got %0d queued expected 0", m_q.size());
    else pass_cnt++;
  endtask

  task automatic apply_reset();
    reset_n = 0; in_valid = 0; in_sof = 0; clr_err = 0; st_if.ready = 0;
    model_clear();
    @(negedge clk); @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    logic acc;
    st_if.ready = 0;
    #1 reset_n = 0;
    #2;
    chk_cnt += 8;
    if (st_if.valid !== 1'b0) $display("FAIL rst_st_valid: got %b expected 0", st_if.valid); else pass_cnt++;
    if (st_if.data !== 8'h00) $display("FAIL rst_st_data: got %02h expected 00", st_if.data); else pass_cnt++;
    if (st_if.sop !== 1'b0) $display("FAIL rst_st_sop: got %b expected 0", st_if.sop); else pass_cnt++;
    if (st_if.eop !== 1'b0) $display("FAIL rst_st_eop: got %b expected 0", st_if.eop); else pass_cnt++;
    if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", in_ready); else pass_cnt++;
    if (frame_cnt !== 2'd0) $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); else pass_cnt++;
    if (err_sof !== 1'b0) $display("FAIL rst_err_sof: got %b expected 0", err_sof); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
    model_clear();
    @(negedge clk);
    reset_n = 1;
    step(0, 0, 8'h00, 1, 1, 0, acc);
  endtask

  task automatic test_basic_frame();
    pops = 0;
    send_pixel(8'h10, 1, 1, 0);
    chk_cnt++;
    if (st_if.valid !== 1'b1) $display("FAIL first_latency: got st_valid=%b expected 1", st_if.valid);
    else pass_cnt++;
    for (int i = 1; i < 8; i++) send_pixel(8'(8'h10 + i), 0, 1, 0);
    drain();
    chk_cnt += 3;
    if (frame_cnt !== 2'd1) $display("FAIL basic_frame_cnt: got %0d expected 1", frame_cnt); else pass_cnt++;
    if (err_sof !== 1'b0) $display("FAIL basic_err: got %b expected 0", err_sof); else pass_cnt++;
    if (pops != 8) $display("FAIL basic_pops: got %0d expected 8", pops); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic acc;
    logic [7:0] held;
    int idx;
    pops = 0; idx = 0;
    for (int c = 0; c < 8; c++) begin
      step(1, idx == 0, 8'(8'h10 + idx), 0, 1, 0, acc);
      if (acc) idx++;
    end
    chk_cnt += 2;
    if (idx != 4) $display("FAIL bp_accepted: got %0d expected 4", idx); else pass_cnt++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready); else pass_cnt++;
    held = st_if.data;
    repeat (3) step(1, 0, 8'(8'h10 + idx), 0, 1, 0, acc);
    chk_cnt++;
    if (st_if.data !== held || held !== 8'h10)
      $display("FAIL bp_stable: got %02h expected %02h", st_if.data, 8'h10);
    else pass_cnt++;
    while (idx < 8) begin
      send_pixel(8'(8'h10 + idx), 0, 1, 0);
      idx++;
    end
    drain();
    chk_cnt += 2;
    if (pops != 8) $display("FAIL bp_pops: got %0d expected 8", pops); else pass_cnt++;
    if (frame_cnt !== 2'd2) $display("FAIL bp_frame_cnt: got %0d expected 2", frame_cnt); else pass_cnt++;
  endtask

  task automatic test_framing_error();
    logic acc;
    for (int i = 0; i < 12; i++) begin
      send_pixel(8'(8'h20 + i), (i == 0) || (i == 4), 2, 0);
      if (i == 4) begin
        chk_cnt++;
        if (err_sof !== 1'b1) $display("FAIL ferr_set: got %b expected 1", err_sof); else pass_cnt++;
      end
    end
    drain();
    step(0, 0, 8'h00, 1, 1, 1, acc);
    chk_cnt++;
    if (err_sof !== 1'b0) $display("FAIL ferr_clear: got %b expected 0", err_sof); else pass_cnt++;
    send_pixel(8'h30, 1, 1, 0);
    send_pixel(8'h31, 1, 1, 1);
    chk_cnt++;
    if (err_sof !== 1'b1) $display("FAIL ferr_set_priority: got %b expected 1", err_sof); else pass_cnt++;
    for (int i = 2; i < 9; i++) send_pixel(8'(8'h30 + i), 0, 1, 0);
    drain();
  endtask

  task automatic test_orphan();
    logic acc;
    step(0, 0, 8'h00, 1, 1, 1, acc);
    send_pixel(8'h55, 0, 0, 0);
    chk_cnt += 2;
    if (err_sof !== 1'b1) $display("FAIL orphan_err: got %b expected 1", err_sof); else pass_cnt++;
    if ({st_if.sop, st_if.eop, st_if.data} !== 10'h055)
      $display("FAIL orphan_head: got sop=%b eop=%b data=%02h expected sop=0 eop=0 data=55",
               st_if.sop, st_if.eop, st_if.data);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid_packet();
    logic acc;
    for (int i = 0; i < 3; i++) send_pixel(8'(8'h60 + i), i == 0, 0, 0);
    step(0, 0, 8'h00, 1, 1, 0, acc);
    #2 reset_n = 0;
    #1;
    chk_cnt += 3;
    if (st_if.valid !== 1'b0) $display("FAIL rmid_st_valid: got %b expected 0", st_if.valid); else pass_cnt++;
    if (in_ready !== 1'b0) $display("FAIL rmid_in_ready: got %b expected 0", in_ready); else pass_cnt++;
    if (frame_cnt !== 2'd0) $display("FAIL rmid_frame_cnt: got %0d expected 0", frame_cnt); else pass_cnt++;
    model_clear();
    @(negedge clk);
    reset_n = 1;
    pops = 0;
    for (int i = 0; i < 8; i++) send_pixel(8'(8'h40 + i), i == 0, 2, 0);
    drain();
    chk_cnt += 2;
    if (frame_cnt !== 2'd1) $display("FAIL rmid_frame: got %0d expected 1", frame_cnt); else pass_cnt++;
    if (pops != 8) $display("FAIL rmid_pops: got %0d expected 8", pops); else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    apply_reset();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 8; i++) send_pixel(8'($urandom), i == 0, 2, 0);
      drain();
      chk_cnt++;
      if (frame_cnt !== exp_seq[f])
        $display("FAIL wrap_frame_cnt[%0d]: got %0d expected %0d", f, frame_cnt, exp_seq[f]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic acc, sof;
    for (int c = 0; c < 800; c++) begin
      sof = m_in_frame ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 7) != 0);
      step($urandom_range(0, 3) != 0, sof, 8'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 19) == 0, acc);
    end
    drain();
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0; pops = 0;
    st_if.ready = 0;
    model_clear();
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_framing_error();
    test_orphan();
    test_reset_mid_packet();
    test_counter_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
